btn_debounce: RTL and testbench

//  Debounces the board push-buttons and emits clean levels plus one-cycle press/release pulses.

---
 rtl/btn_debounce_pkg.sv | 27 ++
 rtl/btn_debounce_fsm.sv | 100 ++++++++++
 rtl/btn_debounce.sv | 71 +++++++
 tb/tb_btn_debounce.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_pkg
//  Description : Shared state encodings and defaults for the push-button
//                debouncer and its per-button FSM.
//  Revision    : 1.0  initial release
// ============================================================================
package btn_debounce_pkg;

    // Per-button debounce states
    typedef enum logic [1:0] {
        DB_IDLE   = 2'd0,
        DB_CHK_HI = 2'd1,
        DB_HIGH   = 2'd2,
        DB_CHK_LO = 2'd3
    } db_state_t;

    // Consecutive equal samples needed before a level change is accepted
    localparam int DEF_STABLE_CNT = 4;

    // Run-length counter width; must hold the value STABLE_CNT itself
    function automatic int db_cnt_width(input int stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction

endpackage : btn_debounce_pkg
`default_nettype wire

// File: rtl/btn_debounce_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_fsm
//  Description : Debounce state machine for one button. Advances only on the
//                sample tick; any sample that breaks a run discards it.
//                Level and pulses are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce_fsm
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic s,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = db_cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    db_state_t       state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;

    // Saturating increment so the run counter can never wrap
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // State, run counter and registered outputs; pulses default low each clk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= DB_IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (tick) begin
                case (state)
                    DB_IDLE: begin
                        if (s) begin
                            state <= DB_CHK_HI;
                            cnt   <= CNT_ONE;
                        end
                    end
                    DB_CHK_HI: begin
                        if (s) begin
                            if (cnt_inc == CNT_MAX) begin
                                state       <= DB_HIGH;
                                cnt         <= '0;
                                level       <= 1'b1;
                                press_pulse <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= DB_IDLE;
                            cnt   <= '0;
                        end
                    end
                    DB_HIGH: begin
                        if (!s) begin
                            state <= DB_CHK_LO;
                            cnt   <= CNT_ONE;
                        end
                    end
                    DB_CHK_LO: begin
                        if (!s) begin
                            if (cnt_inc == CNT_MAX) begin
                                state         <= DB_IDLE;
                                cnt           <= '0;
                                level         <= 1'b0;
                                release_pulse <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= DB_HIGH;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= DB_IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : btn_debounce_fsm
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Push-button debouncer. Synchronizes the raw buttons and a
//                slow divider tap, turns tap rising edges into one-clk sample
//                ticks, and runs one debounce FSM per button.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int SYNC_STG   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clkdiv_tap,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    logic [SYNC_STG-1:0] tap_sync;
    logic [N_BTN-1:0]    btn_sync [SYNC_STG];
    logic                tap_s;
    logic                tap_prev;
    logic                tick;

    assign tap_s = tap_sync[SYNC_STG-1];

    // tap_prev resets to 0, so a tap already high after reset yields a tick
    assign tick = tap_s & ~tap_prev;

    // Synchronizer chains for the tap and buttons, plus the tap edge history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap_sync <= '0;
            tap_prev <= 1'b0;
            for (int i = 0; i < SYNC_STG; i++) begin
                btn_sync[i] <= '0;
            end
        end else begin
            tap_sync    <= {tap_sync[SYNC_STG-2:0], clkdiv_tap};
            tap_prev    <= tap_s;
            btn_sync[0] <= btn_raw;
            for (int i = 1; i < SYNC_STG; i++) begin
                btn_sync[i] <= btn_sync[i-1];
            end
        end
    end

    generate
        for (genvar g = 0; g < N_BTN; g++) begin : g_btn
            btn_debounce_fsm #(
                .STABLE_CNT (STABLE_CNT)
            ) u_fsm (
                .clk           (clk),
                .rst_n         (rst_n),
                .tick          (tick),
                .s             (btn_sync[SYNC_STG-1][g]),
                .level         (btn_level[g]),
                .press_pulse   (btn_press[g]),
                .release_pulse (btn_release[g])
            );
        end
    endgenerate

endmodule : btn_debounce
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce
//  Description : Directed self-checking bench for btn_debounce.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_debounce;

    logic       clk;
    logic       rst_n;
    logic       clkdiv_tap;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int tests_run;
    int tests_failed;

    // Snapshots taken in the cycle a pulse from the latest tick must appear
    logic [3:0] snap_press;
    logic [3:0] snap_release;

    // Pulse-cycle counters; a 1-clk pulse adds exactly one
    int press_cnt   [4];
    int release_cnt [4];
    int overlap_cnt;

    btn_debounce #(
        .N_BTN      (4),
        .STABLE_CNT (4),
        .SYNC_STG   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clkdiv_tap  (clkdiv_tap),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) begin
            press_cnt[i]   = 0;
            release_cnt[i] = 0;
        end
        overlap_cnt = 0;
    end

    // Accumulate pulse cycles seen at each clock edge
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (btn_press[i])   press_cnt[i]   <= press_cnt[i] + 1;
            if (btn_release[i]) release_cnt[i] <= release_cnt[i] + 1;
        end
        if ((btn_press & btn_release) != 4'h0) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 16-clk tap period; raw is settled through the synchronizer first.
    // Tap rises just after an edge, tick is seen at the 2nd edge, the pulse
    // register loads at the 3rd edge and is snapshotted 1 ns later.
    task automatic do_tick(input logic [3:0] raw);
        btn_raw = raw;
        step(4);
        clkdiv_tap = 1'b1;
        step(3);
        snap_press   = btn_press;
        snap_release = btn_release;
        step(5);
        clkdiv_tap = 1'b0;
        step(4);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        clkdiv_tap   = 1'b0;
        btn_raw      = 4'hF;
        @(posedge clk);
        #1;

        // 1. Reset with buttons pressed and tap toggling
        for (int i = 0; i < 3; i++) begin
            clkdiv_tap = ~clkdiv_tap;
            step(1);
        end
        check("reset_level",   btn_level,   4'h0);
        check("reset_press",   btn_press,   4'h0);
        check("reset_release", btn_release, 4'h0);
        clkdiv_tap = 1'b0;
        btn_raw    = 4'h0;
        step(2);
        rst_n = 1'b1;
        step(4);

        // 2. Clean press on button 0
        for (int t = 1; t <= 3; t++) begin
            do_tick(4'h1);
            check("press0_early", snap_press, 4'h0);
            check("level0_early", btn_level,  4'h0);
        end
        do_tick(4'h1);
        check("press0_pulse", snap_press, 4'h1);
        check("level0_high",  btn_level,  4'h1);
        check("press0_count", press_cnt[0], 1);

        // 3. Bounce on button 1: 1,1,0,1,1,1,1
        do_tick(4'h3);
        do_tick(4'h3);
        do_tick(4'h1);
        check("bounce1_level", btn_level, 4'h1);
        do_tick(4'h3);
        do_tick(4'h3);
        do_tick(4'h3);
        check("bounce1_tick6", snap_press, 4'h0);
        check("bounce1_cnt6",  press_cnt[1], 0);
        do_tick(4'h3);
        check("bounce1_pulse", snap_press, 4'h2);
        check("bounce1_lvl",   btn_level,  4'h3);
        check("bounce1_count", press_cnt[1], 1);

        // 4. Single low glitch on button 0 is ignored, then a real release
        do_tick(4'h2);
        check("glitch0_lvl",  btn_level, 4'h3);
        do_tick(4'h3);
        check("glitch0_rel",  snap_release, 4'h0);
        check("glitch0_lvl2", btn_level, 4'h3);
        for (int t = 1; t <= 3; t++) begin
            do_tick(4'h2);
            check("rel0_early", snap_release, 4'h0);
        end
        check("rel0_lvl_hold", btn_level, 4'h3);
        do_tick(4'h2);
        check("rel0_pulse", snap_release, 4'h1);
        check("rel0_level", btn_level,    4'h2);
        check("rel0_count", release_cnt[0], 1);

        // 5. Release button 1, then press 3 and 1 together
        for (int t = 0; t < 4; t++) do_tick(4'h0);
        check("rel1_pulse", snap_release, 4'h2);
        check("all_low",    btn_level,    4'h0);
        for (int t = 0; t < 4; t++) do_tick(4'hA);
        check("simul_press", snap_press, 4'hA);
        check("simul_level", btn_level,  4'hA);
        check("press3_cnt",  press_cnt[3], 1);
        check("press1_cnt",  press_cnt[1], 2);

        // 6. Press button 2, then reset while it is high
        for (int t = 0; t < 4; t++) do_tick(4'hE);
        check("press2_pulse", snap_press, 4'h4);
        check("press2_level", btn_level,  4'hE);
        rst_n = 1'b0;
        step(1);
        check("midrst_level",   btn_level,   4'h0);
        check("midrst_release", btn_release, 4'h0);
        step(1);
        rst_n   = 1'b1;
        btn_raw = 4'h0;
        step(4);
        check("midrst_rel_cnt2", release_cnt[2], 0);

        // Frozen tap: bring button 2 high, then toggle raw with tap stuck
        for (int t = 0; t < 4; t++) do_tick(4'h4);
        check("repress2_level", btn_level, 4'h4);
        check("repress2_cnt",   press_cnt[2], 2);
        for (int i = 0; i < 1000; i++) begin
            btn_raw = btn_raw ^ 4'hF;
            step(1);
        end
        check("frozen0_level", btn_level, 4'h4);
        btn_raw = 4'h4;
        step(4);
        clkdiv_tap = 1'b1;
        step(8);
        for (int i = 0; i < 1000; i++) begin
            btn_raw = btn_raw ^ 4'hF;
            step(1);
        end
        check("frozen1_level", btn_level, 4'h4);
        check("frozen_press",  press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 6);
        check("frozen_rel",    release_cnt[0] + release_cnt[1] + release_cnt[2] + release_cnt[3], 2);
        check("no_overlap",    overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_btn_debounce
`default_nettype wire
